// File: rtl/tdm_demux8.sv
// Eight-channel TDM demultiplexer: collects a frame of eight samples, aligned
// by a sync beat, and presents each completed frame on y with a one-cycle strobe.
module tdm_demux8 #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 sync,
   output logic [8*WIDTH-1:0]   y,
   output logic [2:0]           sel,
   output logic                 locked,
   output logic                 frame_valid,
   output logic                 frame_err
);

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [2:0]                cnt_q, cnt_d;
   logic [7:0][WIDTH-1:0]     shadow_q, shadow_d;
   logic [8*WIDTH-1:0]        y_q, y_d;
   logic                      frame_valid_q, frame_valid_d;
   logic                      frame_err_q, frame_err_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shadow_d      = shadow_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;

      if (din_valid) begin
         case (state_q)
            HUNT: begin
               if (sync) begin
                  shadow_d[0] = din;
                  cnt_d       = 3'd1;
                  state_d     = RUN;
               end
            end
            RUN: begin
               // A sync away from slot 0 restarts the frame; stale slots get
               // overwritten before the next frame can complete.
               if (sync && (cnt_q != 3'd0)) begin
                  frame_err_d = 1'b1;
                  shadow_d[0] = din;
                  cnt_d       = 3'd1;
               end else begin
                  shadow_d[cnt_q] = din;
                  cnt_d           = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     for (int k = 0; k < 7; k++) begin
                        y_d[k*WIDTH +: WIDTH] = shadow_q[k];
                     end
                     y_d[7*WIDTH +: WIDTH] = din;
                     frame_valid_d         = 1'b1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         cnt_q         <= 3'd0;
         shadow_q      <= '0;
         y_q           <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
         y_q           <= y_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign y           = y_q;
   assign sel         = cnt_q;
   assign locked      = (state_q == RUN);
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8 (WIDTH=4): vector table, directed corner
// sequences and a randomized run against a queue-based frame model.
module tb_tdm_demux8;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic [W-1:0]   din;
   logic           din_valid;
   logic           sync;
   logic [8*W-1:0] y;
   logic [2:0]     sel;
   logic           locked;
   logic           frame_valid;
   logic           frame_err;

   int checks = 0;
   int errors = 0;

   tdm_demux8 #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .y           (y),
      .sel         (sel),
      .locked      (locked),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: frame assembly as a queue of accepted samples.
   bit             m_locked;
   logic [W-1:0]   m_q[$];
   logic [8*W-1:0] m_y;
   bit             m_fv;
   bit             m_fe;

   task automatic modelReset();
      m_locked = 0;
      m_q.delete();
      m_y  = '0;
      m_fv = 0;
      m_fe = 0;
   endtask

   task automatic modelStep(input bit v, input bit s, input logic [W-1:0] d);
      m_fv = 0;
      m_fe = 0;
      if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_locked = 1;
               m_q = {d};
            end
         end else if (s && m_q.size() != 0) begin
            m_fe = 1;
            m_q = {d};
         end else begin
            m_q.push_back(d);
            if (m_q.size() == 8) begin
               for (int k = 0; k < 8; k++) m_y[k*W +: W] = m_q[k];
               m_fv = 1;
               m_q.delete();
            end
         end
      end
   endtask

   // Checking helpers: each compared field counts as one check.
   task automatic checkInt(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [2:0] e_sel,
                              input logic e_lock, input logic e_fv,
                              input logic e_fe, input logic [8*W-1:0] e_y);
      checks += 5;
      if (sel !== e_sel) begin
         errors++;
         $display("[TB] FAIL %s.sel got %0d expected %0d", name, sel, e_sel);
      end
      if (locked !== e_lock) begin
         errors++;
         $display("[TB] FAIL %s.locked got %b expected %b", name, locked, e_lock);
      end
      if (frame_valid !== e_fv) begin
         errors++;
         $display("[TB] FAIL %s.frame_valid got %b expected %b", name, frame_valid, e_fv);
      end
      if (frame_err !== e_fe) begin
         errors++;
         $display("[TB] FAIL %s.frame_err got %b expected %b", name, frame_err, e_fe);
      end
      if (y !== e_y) begin
         errors++;
         $display("[TB] FAIL %s.y got %h expected %h", name, y, e_y);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, 3'(m_q.size()), m_locked, m_fv, m_fe, m_y);
   endtask

   // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
   task automatic applyStimulus(input bit v, input bit s, input logic [W-1:0] d);
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      #1;
      modelStep(v, s, d);
   endtask

   task automatic doReset(input string name);
      rst_n     = 1'b0;
      din_valid = 1'b0;
      sync      = 1'b0;
      din       = '0;
      #2;
      modelReset();
      checkOutput(name, 3'd0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit             rst_before;
      bit             v;
      bit             s;
      logic [W-1:0]   d;
      logic [2:0]     e_sel;
      bit             e_lock;
      bit             e_fv;
      bit             e_fe;
      logic [8*W-1:0] e_y;
   } vec_t;

   function automatic vec_t mk(bit r, bit v, bit s, logic [W-1:0] d, logic [2:0] es,
                               bit el, bit ef, bit ee, logic [8*W-1:0] ey);
      vec_t t;
      t.rst_before = r; t.v = v; t.s = s; t.d = d;
      t.e_sel = es; t.e_lock = el; t.e_fv = ef; t.e_fe = ee; t.e_y = ey;
      return t;
   endfunction

   vec_t           tbl[14];
   logic [W-1:0]   fr[0:2][0:7];
   int             pulses[$];
   int             fv_count;

   function automatic logic [8*W-1:0] packFrame(input int f);
      logic [8*W-1:0] r;
      for (int k = 0; k < 8; k++) r[k*W +: W] = fr[f][k];
      return r;
   endfunction

   initial begin
      // Frame 1,0,1,1,0,0,1,0 then an idle cycle; then five unsynced beats.
      tbl[0]  = mk(1, 1, 1, 4'h1, 3'd1, 1, 0, 0, 32'h0);
      tbl[1]  = mk(0, 1, 0, 4'h0, 3'd2, 1, 0, 0, 32'h0);
      tbl[2]  = mk(0, 1, 0, 4'h1, 3'd3, 1, 0, 0, 32'h0);
      tbl[3]  = mk(0, 1, 0, 4'h1, 3'd4, 1, 0, 0, 32'h0);
      tbl[4]  = mk(0, 1, 0, 4'h0, 3'd5, 1, 0, 0, 32'h0);
      tbl[5]  = mk(0, 1, 0, 4'h0, 3'd6, 1, 0, 0, 32'h0);
      tbl[6]  = mk(0, 1, 0, 4'h1, 3'd7, 1, 0, 0, 32'h0);
      tbl[7]  = mk(0, 1, 0, 4'h0, 3'd0, 1, 1, 0, 32'h01001101);
      tbl[8]  = mk(0, 0, 0, 4'h7, 3'd0, 1, 0, 0, 32'h01001101);
      tbl[9]  = mk(1, 1, 0, 4'h1, 3'd0, 0, 0, 0, 32'h0);
      tbl[10] = mk(0, 1, 0, 4'h5, 3'd0, 0, 0, 0, 32'h0);
      tbl[11] = mk(0, 1, 0, 4'hF, 3'd0, 0, 0, 0, 32'h0);
      tbl[12] = mk(0, 1, 0, 4'h3, 3'd0, 0, 0, 0, 32'h0);
      tbl[13] = mk(0, 1, 0, 4'h9, 3'd0, 0, 0, 0, 32'h0);

      rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0;
      modelReset();

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].rst_before) doReset($sformatf("tbl%0d.reset", i));
         applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d);
         checkOutput($sformatf("tbl%0d", i), tbl[i].e_sel, tbl[i].e_lock,
                     tbl[i].e_fv, tbl[i].e_fe, tbl[i].e_y);
      end

      // Misplaced sync: y must hold, frame_err pulses once, new frame starts at A.
      doReset("s31.reset");
      for (int k = 0; k < 8; k++) applyStimulus(1, k == 0, 4'(k + 1));
      checkOutput("s31.frame1", 3'd0, 1, 1, 0, 32'h87654321);
      applyStimulus(1, 1, 4'h3);
      applyStimulus(1, 0, 4'h4);
      applyStimulus(1, 0, 4'h5);
      checkOutput("s31.partial", 3'd3, 1, 0, 0, 32'h87654321);
      applyStimulus(1, 1, 4'hA);
      checkOutput("s31.err", 3'd1, 1, 0, 1, 32'h87654321);
      applyStimulus(0, 0, 4'h0);
      checkOutput("s31.errgone", 3'd1, 1, 0, 0, 32'h87654321);
      applyStimulus(1, 0, 4'hB); applyStimulus(1, 0, 4'hC);
      applyStimulus(1, 0, 4'hD); applyStimulus(1, 0, 4'hE);
      applyStimulus(1, 0, 4'hF); applyStimulus(1, 0, 4'h1);
      checkModel("s31.ch6");
      applyStimulus(1, 0, 4'h2);
      checkOutput("s31.frame2", 3'd0, 1, 1, 0, 32'h21FEDCBA);

      // Gapped delivery gives the same frame as the gap-free vector case.
      doReset("s32.reset");
      fv_count = 0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, k == 0, tbl[k].d);
         if (frame_valid) fv_count++;
         if (k == 7) checkOutput("s32.done", 3'd0, 1, 1, 0, 32'h01001101);
         else checkModel($sformatf("s32.beat%0d", k));
         applyStimulus(0, 1, 4'hF);
         if (frame_valid) fv_count++;
         checkModel($sformatf("s32.gap%0d", k));
      end
      checkInt("s32.fv_count", fv_count, 1);

      // Reset mid-frame wipes y and the partial frame; unsynced beats ignored.
      doReset("s33.reset");
      for (int k = 0; k < 8; k++) applyStimulus(1, k == 0, 4'(k + 8));
      checkOutput("s33.frame", 3'd0, 1, 1, 0, 32'hFEDCBA98);
      for (int k = 0; k < 6; k++) applyStimulus(1, k == 0, 4'(k));
      checkOutput("s33.ch5", 3'd6, 1, 0, 0, 32'hFEDCBA98);
      doReset("s33.midreset");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 4'h5);
         checkOutput($sformatf("s33.ignored%0d", k), 3'd0, 0, 0, 0, 32'h0);
      end

      // Three back-to-back frames, sync only on the very first beat.
      doReset("s34.reset");
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 8; k++) fr[f][k] = 4'($urandom);
      pulses.delete();
      for (int b = 0; b < 24; b++) begin
         applyStimulus(1, b == 0, fr[b / 8][b % 8]);
         checkModel($sformatf("s34.beat%0d", b));
         if (frame_valid) begin
            pulses.push_back(b);
            checkOutput($sformatf("s34.frame%0d", b / 8), 3'd0, 1, 1, 0, packFrame(b / 8));
         end
      end
      checkInt("s34.pulse_count", pulses.size(), 3);
      for (int p = 0; p < pulses.size(); p++)
         checkInt($sformatf("s34.pulse%0d_beat", p), pulses[p], 8 * p + 7);

      // Randomized traffic against the model.
      doReset("rand.reset");
      for (int c = 0; c < 800; c++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, 4'($urandom));
         checkModel($sformatf("rand.c%0d", c));
         checkInt($sformatf("rand.excl%0d", c), int'(frame_valid & frame_err), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
